vend_fsm_param: RTL and testbench

Parametrised successor to the fixed two-coin, fixed-price vending controller. It accepts two coin denominations and accumulates credit in a CREDIT_W-bit register. When credit reaches PRICE it dispenses one item, then returns the excess as a serial stream of coin pulses. It also supports cancel/refund and coin rejection, and sits between the coin-acceptor decode and the dispenser/change-hopper drivers.

---
 rtl/vend_fsm_param_if.sv | 39 +++
 rtl/vend_fsm_param.sv | 188 ++++++++++++++++++
 tb/tb_vend_fsm_param.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_fsm_param_if.sv
// Coin-side / dispenser-side bundle for vend_fsm_param.
// master: coin-acceptor decode that drives coins and cancel, and reads back the results.
// slave:  the vending controller itself.
// Optional macro VEND_AUDIT_EN adds the sales_cnt / refund_cnt audit counters.
interface vend_fsm_param_if #(
    parameter int CREDIT_W = 8
`ifdef VEND_AUDIT_EN
    , parameter int AUDIT_W = 16
`endif
);
    logic [1:0]          in;
    logic                cancel;
    logic                out;
    logic                change_a;
    logic                change_b;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
`ifdef VEND_AUDIT_EN
    logic [AUDIT_W-1:0]  sales_cnt;
    logic [AUDIT_W-1:0]  refund_cnt;
`endif

    modport master (
        output in, cancel,
        input  out, change_a, change_b, coin_reject, busy, credit
`ifdef VEND_AUDIT_EN
        , input sales_cnt, refund_cnt
`endif
    );

    modport slave (
        input  in, cancel,
        output out, change_a, change_b, coin_reject, busy, credit
`ifdef VEND_AUDIT_EN
        , output sales_cnt, refund_cnt
`endif
    );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised two-coin vending controller: credit accumulation, single-item
// dispense, greedy serial change return, cancel/refund and coin rejection.
// Optional macro VEND_AUDIT_EN adds saturating sales/refund audit counters.
//
// state   | meaning
// COLLECT | accepting coins and cancel requests
// VEND    | one-cycle dispense pulse on out
// CHANGE  | returning remaining credit, one coin pulse per cycle
module vend_fsm_param #(
    parameter int CREDIT_W   = 8,
    parameter int PRICE      = 15,
    parameter int COIN_A_VAL = 5,
    parameter int COIN_B_VAL = 10
`ifdef VEND_AUDIT_EN
    , parameter int AUDIT_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    vend_fsm_param_if.slave bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    // One extra bit so an overflowing sum is visible before it is committed.
    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] A_X     = (CREDIT_W+1)'(COIN_A_VAL);
    localparam logic [CREDIT_W:0] B_X     = (CREDIT_W+1)'(COIN_B_VAL);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                out_q, out_d;
    logic                change_a_q, change_a_d;
    logic                change_b_q, change_b_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W:0]   credit_x;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                take_b;
    logic                take_a;
    logic [CREDIT_W-1:0] credit_step;
    logic                cancel_acc;

    assign credit_x   = {1'b0, credit_q};
    assign sum        = credit_x + coin_val;
    assign cancel_acc = (state_q == COLLECT) && bus.cancel && (credit_q != '0);

    // Value of the coin sampled this cycle (invalid code counts as nothing).
    always_comb begin
        coin_val = '0;
        case (bus.in)
            2'b01:   coin_val = A_X;
            2'b10:   coin_val = B_X;
            default: coin_val = '0;
        endcase
    end

    // Greedy change step on the current credit; no pulse if below the small coin.
    always_comb begin
        take_b      = (credit_x >= B_X);
        take_a      = !take_b && (credit_x >= A_X);
        credit_step = credit_q;
        if (take_b) begin
            credit_step = CREDIT_W'(credit_x - B_X);
        end else if (take_a) begin
            credit_step = CREDIT_W'(credit_x - A_X);
        end
    end

    // Next-state and next-output decode; pulses are registered so each one
    // lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        out_d      = 1'b0;
        change_a_d = 1'b0;
        change_b_d = 1'b0;
        reject_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.cancel) begin
                    // Cancel takes priority: any coin arriving alongside it goes back.
                    reject_d = (bus.in != 2'b00);
                    if (cancel_acc) begin
                        state_d    = CHANGE;
                        change_b_d = take_b;
                        change_a_d = take_a;
                        credit_d   = credit_step;
                    end
                end else if (bus.in == 2'b11) begin
                    reject_d = 1'b1;
                end else if (bus.in != 2'b00) begin
                    if (sum[CREDIT_W]) begin
                        reject_d = 1'b1;
                    end else if (sum >= PRICE_X) begin
                        credit_d = CREDIT_W'(sum - PRICE_X);
                        state_d  = VEND;
                        out_d    = 1'b1;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end
            VEND: begin
                reject_d = (bus.in != 2'b00);
                if (credit_q != '0) begin
                    state_d    = CHANGE;
                    change_b_d = take_b;
                    change_a_d = take_a;
                    credit_d   = credit_step;
                end else begin
                    state_d = COLLECT;
                end
            end
            CHANGE: begin
                reject_d = (bus.in != 2'b00);
                if (credit_x < A_X) begin
                    // Zero, or a residue no coin can represent: forfeit and finish.
                    credit_d = '0;
                    state_d  = COLLECT;
                end else begin
                    change_b_d = take_b;
                    change_a_d = take_a;
                    credit_d   = credit_step;
                end
            end
            default: begin
                state_d  = COLLECT;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            credit_q   <= '0;
            out_q      <= 1'b0;
            change_a_q <= 1'b0;
            change_b_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            out_q      <= out_d;
            change_a_q <= change_a_d;
            change_b_q <= change_b_d;
            reject_q   <= reject_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.change_a    = change_a_q;
    assign bus.change_b    = change_b_q;
    assign bus.coin_reject = reject_q;
    assign bus.busy        = (state_q != COLLECT);
    assign bus.credit      = credit_q;

`ifdef VEND_AUDIT_EN
    logic [AUDIT_W-1:0] sales_q;
    logic [AUDIT_W-1:0] refund_q;

    // Saturating audit counters: one sale per VEND cycle, one refund per accepted cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            sales_q  <= '0;
            refund_q <= '0;
        end else begin
            if ((state_q == VEND) && (sales_q != '1)) begin
                sales_q <= sales_q + 1'b1;
            end
            if (cancel_acc && (refund_q != '1)) begin
                refund_q <= refund_q + 1'b1;
            end
        end
    end

    assign bus.sales_cnt  = sales_q;
    assign bus.refund_cnt = refund_q;
`endif

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: the driver feeds a transaction-level
// model that pushes the expected output of each cycle; a monitor pops and
// compares after every clock edge. A second, 4-bit-credit instance covers
// the accumulator-overflow rejection.
module tb_vend_fsm_param;

    localparam int CW    = 8;
    localparam int PRICE = 15;
    localparam int CA    = 5;
    localparam int CB    = 10;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int CMAX  = 65535;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    vend_fsm_param_if #(
        .CREDIT_W(CW)
`ifdef VEND_AUDIT_EN
        , .AUDIT_W(16)
`endif
    ) bus ();

    vend_fsm_param #(
        .CREDIT_W(CW), .PRICE(PRICE), .COIN_A_VAL(CA), .COIN_B_VAL(CB)
`ifdef VEND_AUDIT_EN
        , .AUDIT_W(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vend_fsm_param_if #(
        .CREDIT_W(4)
`ifdef VEND_AUDIT_EN
        , .AUDIT_W(16)
`endif
    ) sbus ();

    vend_fsm_param #(
        .CREDIT_W(4), .PRICE(15), .COIN_A_VAL(5), .COIN_B_VAL(10)
`ifdef VEND_AUDIT_EN
        , .AUDIT_W(16)
`endif
    ) dut_s (
        .clk(clk),
        .rst(rst_s),
        .bus(sbus)
    );

    typedef struct {
        bit out;
        bit ca;
        bit cb;
        bit rej;
        bit busy;
        int credit;
        int sales;
        int refund;
    } exp_t;

    exp_t sb_q[$];
    exp_t plan_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(bit o, bit ca, bit cb, bit busy, int credit);
        exp_t e;
        e.out = o; e.ca = ca; e.cb = cb; e.rej = 1'b0; e.busy = busy;
        e.credit = credit; e.sales = 0; e.refund = 0;
        return e;
    endfunction

    // Refund of c: as many large coins as fit, then small coins, remainder lost.
    task automatic push_change(input int c);
        int nb, na, rem;
        nb  = c / CB;
        na  = (c % CB) / CA;
        rem = c;
        if (nb + na == 0) plan_q.push_back(mk(0, 0, 0, 1, c));
        for (int i = 0; i < nb; i++) begin
            rem -= CB;
            plan_q.push_back(mk(0, 0, 1, 1, rem));
        end
        for (int i = 0; i < na; i++) begin
            rem -= CA;
            plan_q.push_back(mk(0, 1, 0, 1, rem));
        end
    endtask

    task automatic model_edge(input logic [1:0] in_v, input bit cancel_v, input bit rst_v);
        exp_t nx;
        int   s_cnt, r_cnt, c, v, s;
        s_cnt = cur.sales;
        r_cnt = cur.refund;
        if (rst_v) begin
            nx = mk(0, 0, 0, 0, 0);
            s_cnt = 0;
            r_cnt = 0;
            plan_q.delete();
        end else begin
            if (cur.out && s_cnt < CMAX) s_cnt++;
            if (cur.busy) begin
                if (plan_q.size() > 0) nx = plan_q.pop_front();
                else nx = mk(0, 0, 0, 0, 0);
                nx.rej = (in_v != 2'b00);
            end else begin
                c  = cur.credit;
                nx = mk(0, 0, 0, 0, c);
                if (cancel_v) begin
                    if (c > 0) begin
                        if (r_cnt < CMAX) r_cnt++;
                        push_change(c);
                        nx = plan_q.pop_front();
                    end
                    nx.rej = (in_v != 2'b00);
                end else if (in_v == 2'b11) begin
                    nx.rej = 1'b1;
                end else if (in_v != 2'b00) begin
                    v = (in_v == 2'b01) ? CA : CB;
                    s = c + v;
                    if (s > MAXC) begin
                        nx.rej = 1'b1;
                    end else if (s >= PRICE) begin
                        nx = mk(1, 0, 0, 1, s - PRICE);
                        if (s > PRICE) push_change(s - PRICE);
                    end else begin
                        nx.credit = s;
                    end
                end
            end
        end
        nx.sales  = s_cnt;
        nx.refund = r_cnt;
        cur = nx;
        sb_q.push_back(nx);
    endtask

    task automatic drive(input logic [1:0] in_v, input bit cancel_v, input bit rst_v);
        @(negedge clk);
        bus.in     = in_v;
        bus.cancel = cancel_v;
        rst        = rst_v;
        model_edge(in_v, cancel_v, rst_v);
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitor: one expected record per clock edge while the main DUT is driven.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (bus.out !== e.out || bus.change_a !== e.ca || bus.change_b !== e.cb ||
                bus.coin_reject !== e.rej || bus.busy !== e.busy ||
                bus.credit !== 8'(e.credit)) begin
                bad++;
                $display("FAIL outputs t=%0t got out=%b ca=%b cb=%b rej=%b busy=%b credit=%0d want out=%b ca=%b cb=%b rej=%b busy=%b credit=%0d",
                         $time, bus.out, bus.change_a, bus.change_b, bus.coin_reject, bus.busy, bus.credit,
                         e.out, e.ca, e.cb, e.rej, e.busy, e.credit);
            end
`ifdef VEND_AUDIT_EN
            total++;
            if (bus.sales_cnt !== 16'(e.sales) || bus.refund_cnt !== 16'(e.refund)) begin
                bad++;
                $display("FAIL audit t=%0t got sales=%0d refund=%0d want sales=%0d refund=%0d",
                         $time, bus.sales_cnt, bus.refund_cnt, e.sales, e.refund);
            end
`endif
        end
    end

    initial begin
        int r;
        logic [1:0] in_r;
        bit can_r, rst_r;
        cur = mk(0, 0, 0, 0, 0);
        bus.in = 2'b00; bus.cancel = 1'b0; rst = 1'b1;
        sbus.in = 2'b00; sbus.cancel = 1'b0; rst_s = 1'b1;

        // reset held with a coin and cancel present
        drive(2'b10, 1, 1); drive(2'b10, 1, 1);
        // exact price
        drive(2'b01, 0, 0); drive(2'b10, 0, 0); drive(2'b00, 0, 0); drive(2'b00, 0, 0);
        // overpay -> one small coin back
        drive(2'b10, 0, 0); drive(2'b10, 0, 0); repeat (3) drive(2'b00, 0, 0);
        // cancel at credit 10 -> one large coin back
        drive(2'b10, 0, 0); drive(2'b00, 1, 0); repeat (2) drive(2'b00, 0, 0);
        // coin together with cancel at credit 5
        drive(2'b01, 0, 0); drive(2'b10, 1, 0); repeat (2) drive(2'b00, 0, 0);
        // invalid code in COLLECT, then clean up with cancel
        drive(2'b01, 0, 0); drive(2'b11, 0, 0); drive(2'b00, 1, 0); repeat (2) drive(2'b00, 0, 0);
        // coin during CHANGE
        drive(2'b10, 0, 0); drive(2'b00, 1, 0); drive(2'b01, 0, 0); drive(2'b00, 0, 0);
        // reset during VEND, then a fresh exact sale
        drive(2'b10, 0, 0); drive(2'b10, 0, 0); drive(2'b00, 0, 1); repeat (2) drive(2'b00, 0, 0);
        drive(2'b01, 0, 0); drive(2'b10, 0, 0); repeat (2) drive(2'b00, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) in_r = 2'b00;
            else if (r < 7) in_r = 2'b01;
            else if (r < 9) in_r = 2'b10;
            else in_r = 2'b11;
            can_r = ($urandom_range(0, 7) == 0);
            rst_r = ($urandom_range(0, 63) == 0);
            drive(in_r, can_r, rst_r);
        end
        repeat (4) drive(2'b00, 0, 0);
        @(posedge clk); #2;
        check("sb_drain", sb_q.size(), 0);

        // narrow accumulator: second large coin would overflow 4 bits
        @(negedge clk); rst_s = 1'b1;
        @(negedge clk); rst_s = 1'b0; sbus.in = 2'b10;
        @(posedge clk); #1;
        check("w4_credit_first", int'(sbus.credit), 10);
        check("w4_rej_first", int'(sbus.coin_reject), 0);
        @(negedge clk); sbus.in = 2'b10;
        @(posedge clk); #1;
        check("w4_rej_overflow", int'(sbus.coin_reject), 1);
        check("w4_credit_kept", int'(sbus.credit), 10);
        @(negedge clk); sbus.in = 2'b01;
        @(posedge clk); #1;
        check("w4_vend", int'(sbus.out), 1);
        check("w4_credit_zero", int'(sbus.credit), 0);
        @(negedge clk); sbus.in = 2'b00;
        @(posedge clk); #1;
        check("w4_idle_busy", int'(sbus.busy), 0);
        check("w4_idle_out", int'(sbus.out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
